// File: rtl/cpu0_div_pkg.sv
// Shared types and constants for the cpu0 iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu0_div_pkg;

  localparam int DIV_DATA_W = 32;

  // Quotient reported for a zero divisor (matches RISC-V DIV/DIVU semantics).
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/cpu0_div_cell_if.sv
// Request/result bundle between the M-stage pipeline and the divide cell.
// Latency: n/a (wires only).
// Backpressure: pipeline stalls on busy; result is qualified by the done pulse.
// master = pipeline side (drives request), slave = divide cell (drives result).
interface cpu0_div_cell_if
  import cpu0_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic              start;
  logic              is_signed;
  logic              flush;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;

  modport master (
    output start, is_signed, flush, src1, src2,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, flush, src1, src2,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/cpu0_div_step.sv
// One restoring radix-2 division step on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
// Ports: rem/dvd_msb/divisor in; rem_next and q_bit out.
module cpu0_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  assign shifted = {rem, dvd_msb};
  // rem < divisor is invariant, so shifted < 2*divisor and the top bit of
  // the DATA_W+1 bit difference is an exact borrow/sign indicator.
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[DATA_W];
  assign rem_next = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
endmodule

// File: rtl/cpu0_div_cell.sv
// Iterative radix-2 DIV/DIVU/REM/REMU cell for the cpu0 M stage.
// Latency: fixed DATA_W+2 cycles from start to done (busy for DATA_W+1 cycles).
// Backpressure: start ignored while busy (no queuing); flush aborts silently.
// Ports: clk, reset_n (sync, active-low), bus (slave modport: start/is_signed/
// flush/src1/src2 in; busy/done/quotient/remainder/div_by_zero out).
module cpu0_div_cell
  import cpu0_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  cpu0_div_cell_if.slave bus
);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
  // Replicated so any DATA_W still gets an all-ones quotient.
  localparam logic [DATA_W-1:0] DZ_QUOT   = {DATA_W{DIV_ZERO_QUOT[0]}};

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;       // dividend magnitude, shifted out msb-first
  logic [DATA_W-1:0] dvsr;      // divisor magnitude
  logic [DATA_W-1:0] rem;       // partial remainder
  logic [DATA_W-1:0] quo;       // quotient magnitude, shifted in lsb-first
  logic [DATA_W-1:0] raw_src1;  // returned as remainder on divide-by-zero
  logic              q_neg;
  logic              r_neg;
  logic              zero_div;

  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] rem_q;
  logic              dz_q;

  // Operand magnitudes; 0x80..0 maps onto itself, which is the correct
  // unsigned magnitude, so signed overflow needs no special case.
  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] src1_mag;
  logic [DATA_W-1:0] src2_mag;

  assign src1_neg = bus.is_signed & bus.src1[DATA_W-1];
  assign src2_neg = bus.is_signed & bus.src2[DATA_W-1];
  assign src1_mag = src1_neg ? -bus.src1 : bus.src1;
  assign src2_mag = src2_neg ? -bus.src2 : bus.src2;

  logic [DATA_W-1:0] rem_next;
  logic              q_bit;

  cpu0_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[DATA_W-1]),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  assign quo_fix = q_neg ? -quo : quo;
  assign rem_fix = r_neg ? -rem : rem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvsr     <= '0;
      rem      <= '0;
      quo      <= '0;
      raw_src1 <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      zero_div <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // flush in the same cycle drops the request
          if (bus.start && !bus.flush) begin
            dvd      <= src1_mag;
            dvsr     <= src2_mag;
            raw_src1 <= bus.src1;
            q_neg    <= src1_neg ^ src2_neg;
            r_neg    <= src1_neg;
            zero_div <= (bus.src2 == '0);
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            rem <= rem_next;
            dvd <= {dvd[DATA_W-2:0], 1'b0};
            quo <= {quo[DATA_W-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) begin
              state <= FIX;
            end
          end
        end

        FIX: begin
          // flush beats the result update: outputs keep their old values
          if (!bus.flush) begin
            quot_q <= zero_div ? DZ_QUOT  : quo_fix;
            rem_q  <= zero_div ? raw_src1 : rem_fix;
            dz_q   <= zero_div;
            done_q <= 1'b1;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_cpu0_div_cell.sv
// Self-checking bench for cpu0_div_cell: table vectors, random operands
// against an arithmetic reference, and abort/re-issue sequences.
// Cycle k below means the interval just after clock edge k.
module tb_cpu0_div_cell;
  import cpu0_div_pkg::*;

  localparam int LAT = 34;

  logic clk;
  logic reset_n;

  cpu0_div_cell_if #(.DATA_W(32)) bus ();

  cpu0_div_cell #(.DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;

  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_dz;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain language-level arithmetic; SV signed / and % truncate
  // toward zero with the remainder taking the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input bit sgn, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; dz = 1'b0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
      dz = 1'b0;
    end
  endfunction

  // Issues start in the current cycle (cycle 0), scrambles operands while
  // busy, optionally re-pulses start at cycle 10, and returns in the done cycle.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input bit sgn, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input bit repulse);
    int done_cyc;
    bit busy_bad;
    done_cyc = 0;
    busy_bad = 0;
    bus.src1 = a;
    bus.src2 = b;
    bus.is_signed = sgn;
    bus.start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      bus.start = 1'b0;
      bus.src1 = $urandom;
      bus.src2 = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad = 1;
      if (repulse && c == 10) bus.start = 1'b1;
    end
    check({name, "_latency"}, 32'(done_cyc), 32'(LAT));
    check({name, "_busy_window"}, {31'd0, busy_bad}, 32'd0);
    check({name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_quotient"}, bus.quotient, eq);
    check({name, "_remainder"}, bus.remainder, er);
    check({name, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
    last_q = eq;
    last_r = er;
    last_dz = edz;
  endtask

  // Runs `n` cycles and reports whether done ever pulsed.
  task automatic no_done_for(input string name, input int n);
    bit seen;
    seen = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (bus.done !== 1'b0) seen = 1;
    end
    check({name, "_no_done"}, {31'd0, seen}, 32'd0);
  endtask

  task automatic check_held(input string name);
    check({name, "_q_held"}, bus.quotient, last_q);
    check({name, "_r_held"}, bus.remainder, last_r);
    check({name, "_dz_held"}, {31'd0, bus.div_by_zero}, {31'd0, last_dz});
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        edz;
    bit          sgn;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[3] = '{32'h1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234,       1'b1};
    vecs[4] = '{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1};
    vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
    vecs[7] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[8] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0};

    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.is_signed = 1'b0;
    bus.src1 = '0;
    bus.src2 = '0;
    repeat (3) tick();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_q", bus.quotient, 32'd0);
    check("reset_r", bus.remainder, 32'd0);
    check("reset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Table vectors, each followed by a done-is-a-pulse / hold check.
    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
            vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
      tick();
      check($sformatf("vec%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      check_held($sformatf("vec%0d_after", i));
    end

    // Random operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sgn = 1'($urandom_range(0, 1));
      ref_div(a, b, sgn, eq, er, edz);
      do_op($sformatf("rnd%0d", i), a, b, sgn, eq, er, edz, 1'b0);
      tick();
    end

    // start re-pulsed during busy is ignored; start in the done cycle is taken.
    do_op("repulse", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 1'b1);
    do_op("done_cycle_start", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
    tick();

    // flush in CALC at cycle 15.
    bus.src1 = 32'd500;
    bus.src2 = 32'd7;
    bus.is_signed = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_done", {31'd0, bus.done}, 32'd0);
    no_done_for("flush", 40);
    check_held("flush");

    // flush in FIX (cycle 33) also suppresses the result.
    bus.src1 = 32'd77;
    bus.src2 = 32'd5;
    bus.start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_fix_busy", {31'd0, bus.busy}, 32'd0);
    no_done_for("flush_fix", 40);
    check_held("flush_fix");

    // flush together with start in IDLE drops the request.
    bus.src1 = 32'd50;
    bus.src2 = 32'd5;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
    no_done_for("flush_start", 40);

    // synchronous reset at cycle 20 discards the operation.
    bus.src1 = 32'd123456;
    bus.src2 = 32'd10;
    bus.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.start = 1'b0;
    end
    reset_n = 1'b0;
    tick();
    check("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_reset_done", {31'd0, bus.done}, 32'd0);
    check("mid_reset_q", bus.quotient, 32'd0);
    check("mid_reset_r", bus.remainder, 32'd0);
    check("mid_reset_dz", {31'd0, bus.div_by_zero}, 32'd0);
    reset_n = 1'b1;
    no_done_for("mid_reset", 40);

    // The unit is usable again after the abort.
    do_op("post_reset", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
